axi_cache_arbiter: RTL and testbench

// - Merges the icache read port and the dcache read/write ports into one AXI master toward the bus bridge.
// - Sits between the cache top level and the external AXI interconnect.
// - Arbitrates reads between the two caches: one read burst in flight at a time.
// - Sequences dcache writes through AW/W/B, one write burst at a time.
// - Holds dcache reads back while a dcache write is still pending, so reads never overtake writes.

---
 rtl/axi_cache_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_cache_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cache_arbiter.sv
// Merges icache reads and dcache reads/writes onto one AXI master: one read burst and one write burst in flight.
// Build option ARB_RR_EN: round-robin read arbitration; without it the dcache wins read ties.
module axi_cache_arbiter #(
    parameter int ID_W = 4,
    parameter int I_ID = 0,
    parameter int D_ID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     i_araddr,
    input  logic [3:0]      i_arlen,
    input  logic [2:0]      i_arsize,
    input  logic            i_arvalid,
    output logic            i_arready,
    output logic [31:0]     i_rdata,
    output logic            i_rlast,
    output logic            i_rvalid,
    input  logic            i_rready,
    input  logic [31:0]     d_araddr,
    input  logic [3:0]      d_arlen,
    input  logic [2:0]      d_arsize,
    input  logic            d_arvalid,
    output logic            d_arready,
    output logic [31:0]     d_rdata,
    output logic            d_rlast,
    output logic            d_rvalid,
    input  logic            d_rready,
    input  logic [31:0]     d_awaddr,
    input  logic [3:0]      d_awlen,
    input  logic [2:0]      d_awsize,
    input  logic            d_awvalid,
    output logic            d_awready,
    input  logic [31:0]     d_wdata,
    input  logic [3:0]      d_wstrb,
    input  logic            d_wlast,
    input  logic            d_wvalid,
    output logic            d_wready,
    output logic            d_bvalid,
    input  logic            d_bready,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic            bvalid,
    output logic            bready,
    output logic [1:0]      dbg_rd_state_o,
    output logic [1:0]      dbg_wr_state_o
);

    // Every channel transfers on a rising edge where valid and ready are both high; the cache-side
    // i_arready/d_arready/d_awready are one-cycle grant pulses raised only while the matching valid is high.
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_e;

    rd_state_e   rd_state_q, rd_state_d;
    wr_state_e   wr_state_q, wr_state_d;
    logic        owner_q, owner_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [3:0]  ar_len_q, ar_len_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [3:0]  aw_len_q, aw_len_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic        d_wins;
    logic        gnt_d;
    logic        gnt_i;
    logic        r_fire;
    logic        unused_rid;

    // rid is not needed: the owner register alone steers read data.
    assign unused_rid = ^rid;

    // dcache reads wait for the write FSM to drain so they never overtake a pending write.
    assign gnt_d = !rst && (rd_state_q == R_IDLE) && d_arvalid && (wr_state_q == W_IDLE)
                   && (d_wins || !i_arvalid);
    assign gnt_i = !rst && (rd_state_q == R_IDLE) && i_arvalid && !gnt_d;

`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;
    assign d_wins       = ~last_owner_q;
    assign last_owner_d = gnt_d ? 1'b1 : (gnt_i ? 1'b0 : last_owner_q);
    always_ff @(posedge clk) begin
        if (rst) last_owner_q <= 1'b0;
        else     last_owner_q <= last_owner_d;
    end
`else
    assign d_wins = 1'b1;
`endif

    always_comb begin
        rd_state_d = rd_state_q;
        owner_d    = owner_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        i_arready  = 1'b0;
        d_arready  = 1'b0;
        arvalid    = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        rready     = 1'b0;
        r_fire     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (gnt_d) begin
                    d_arready  = 1'b1;
                    owner_d    = 1'b1;
                    ar_addr_d  = d_araddr;
                    ar_len_d   = d_arlen;
                    ar_size_d  = d_arsize;
                    rd_state_d = R_AR;
                end else if (gnt_i) begin
                    i_arready  = 1'b1;
                    owner_d    = 1'b0;
                    ar_addr_d  = i_araddr;
                    ar_len_d   = i_arlen;
                    ar_size_d  = i_arsize;
                    rd_state_d = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (owner_q) begin
                    d_rvalid = rvalid;
                    rready   = d_rready;
                    r_fire   = rvalid && d_rready;
                end else begin
                    i_rvalid = rvalid;
                    rready   = i_rready;
                    r_fire   = rvalid && i_rready;
                end
                if (r_fire && rlast) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        d_awready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        d_wready   = 1'b0;
        d_bvalid   = 1'b0;
        bready     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (d_awvalid && !rst) begin
                    d_awready  = 1'b1;
                    aw_addr_d  = d_awaddr;
                    aw_len_d   = d_awlen;
                    aw_size_d  = d_awsize;
                    wr_state_d = W_AW;
                end
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) wr_state_d = W_DATA;
            end
            W_DATA: begin
                wvalid   = d_wvalid;
                d_wready = wready;
                if (d_wvalid && wready && d_wlast) wr_state_d = W_RESP;
            end
            W_RESP: begin
                d_bvalid = bvalid;
                bready   = d_bready;
                if (bvalid && d_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            owner_q    <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            owner_q    <= owner_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
        end
    end

    assign arid    = owner_q ? ID_W'(D_ID) : ID_W'(I_ID);
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arsize  = ar_size_q;
    assign i_rdata = rdata;
    assign i_rlast = rlast;
    assign d_rdata = rdata;
    assign d_rlast = rlast;
    assign awid    = ID_W'(D_ID);
    assign awaddr  = aw_addr_q;
    assign awlen   = aw_len_q;
    assign awsize  = aw_size_q;
    assign wdata   = d_wdata;
    assign wstrb   = d_wstrb;
    assign wlast   = d_wlast;

    assign dbg_rd_state_o = rd_state_q;
    assign dbg_wr_state_o = wr_state_q;

endmodule

// File: tb/tb_axi_cache_arbiter.sv
// Bench for axi_cache_arbiter: AXI slave model, cache-side drivers, and a queue scoreboard with per-cycle rule checks.
module tb_axi_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_araddr, d_araddr, d_awaddr, d_wdata, i_rdata, d_rdata;
    logic [3:0]  i_arlen, d_arlen, d_awlen, d_wstrb;
    logic [2:0]  i_arsize, d_arsize, d_awsize;
    logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
    logic [3:0]  arid, rid, awid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]  dbg_rd_state_o, dbg_wr_state_o;

    axi_cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
        .d_rready(d_rready),
        .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
        .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
        .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bvalid(bvalid), .bready(bready),
        .dbg_rd_state_o(dbg_rd_state_o), .dbg_wr_state_o(dbg_wr_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [39:0] ar_exp_q[$];   // {owner, addr, len, size}
    logic [38:0] aw_exp_q[$];   // {addr, len, size}
    logic [36:0] w_exp_q[$];    // {data, strb, last}
    logic [32:0] ir_exp_q[$];   // {data, last}
    logic [32:0] dr_exp_q[$];
    logic        gnt_q[$];      // 1 = dcache granted
    bit          ar_pend, r_act, r_owner, aw_pend, w_act, b_pend, wr_busy, last_owner;
    bit          data_is_index;
    int          r_beat, r_len, burst_beats;
    logic [31:0] cur_rdata;
    int          i_beats = 0, d_beats = 0, w_beats = 0, b_cnt = 0;
    int          b_cyc = 0, d_gnt_cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- AXI slave driver ----------------
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rlast = 0; rid = 0;
        awready = 0; wready = 0; bvalid = 0;
        i_rready = 0; d_rready = 0; d_bready = 0;
        forever begin
            @(posedge clk); #1;
            arready  = 1'($urandom_range(0, 1));
            rvalid   = r_act && ($urandom_range(0, 3) != 0);
            rdata    = cur_rdata;
            rlast    = r_act && (r_beat == r_len);
            rid      = r_owner ? 4'd1 : 4'd0;
            awready  = 1'($urandom_range(0, 1));
            wready   = ($urandom_range(0, 3) != 0);
            bvalid   = b_pend && ($urandom_range(0, 1) != 0);
            i_rready = ($urandom_range(0, 3) != 0);
            d_rready = ($urandom_range(0, 3) != 0);
            d_bready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic next_beat();
        cur_rdata = data_is_index ? 32'(r_beat) : $urandom;
        if (r_owner) dr_exp_q.push_back({cur_rdata, r_beat == r_len});
        else         ir_exp_q.push_back({cur_rdata, r_beat == r_len});
    endtask

    // ---------------- monitor: reference rules + queue pops ----------------
    logic [39:0] ar_e;
    logic [38:0] aw_e;
    logic [36:0] w_e;
    logic [32:0] r_e;
    bit          rd_busy, d_el, d_pri, exp_i_gnt, exp_d_gnt;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            ar_exp_q.delete(); aw_exp_q.delete(); w_exp_q.delete();
            ir_exp_q.delete(); dr_exp_q.delete();
            ar_pend = 0; r_act = 0; aw_pend = 0; w_act = 0; b_pend = 0; wr_busy = 0;
            last_owner = 0;
        end else begin
            rd_busy = ar_pend || r_act;
            d_el    = d_arvalid && !wr_busy;
`ifdef ARB_RR_EN
            d_pri = !last_owner;
`else
            d_pri = 1'b1;
`endif
            exp_d_gnt = !rd_busy && d_el && (d_pri || !i_arvalid);
            exp_i_gnt = !rd_busy && i_arvalid && !exp_d_gnt;
            check("i_arready", i_arready, exp_i_gnt);
            check("d_arready", d_arready, exp_d_gnt);
            check("d_awready", d_awready, !wr_busy && d_awvalid);
            check("arvalid", arvalid, ar_pend);
            check("awvalid", awvalid, aw_pend);
            check("i_rvalid", i_rvalid, r_act && !r_owner && rvalid);
            check("d_rvalid", d_rvalid, r_act && r_owner && rvalid);
            check("rready", rready, r_act && (r_owner ? d_rready : i_rready));
            check("wvalid", wvalid, w_act && d_wvalid);
            check("d_wready", d_wready, w_act && wready);
            check("d_bvalid", d_bvalid, b_pend && bvalid);
            check("bready", bready, b_pend && d_bready);

            if (i_rvalid && i_rready) begin
                i_beats++;
                if (ir_exp_q.size() == 0) timeout_fail("i_r_unexpected");
                else begin r_e = ir_exp_q.pop_front(); check("i_rbeat", {i_rdata, i_rlast}, r_e); end
            end
            if (d_rvalid && d_rready) begin
                d_beats++;
                if (dr_exp_q.size() == 0) timeout_fail("d_r_unexpected");
                else begin r_e = dr_exp_q.pop_front(); check("d_rbeat", {d_rdata, d_rlast}, r_e); end
            end

            if (arvalid && arready) begin
                ar_pend = 0;
                if (ar_exp_q.size() == 0) timeout_fail("ar_unexpected");
                else begin
                    ar_e = ar_exp_q.pop_front();
                    check("ar_fields", {arid, araddr, arlen, arsize},
                          {(ar_e[39] ? 4'd1 : 4'd0), ar_e[38:0]});
                    r_act = 1; r_owner = ar_e[39]; r_beat = 0; r_len = int'(ar_e[6:3]);
                    burst_beats = 0;
                    next_beat();
                end
            end else if (rvalid && rready && r_act) begin
                burst_beats++;
                if (r_beat == r_len) r_act = 0;
                else begin r_beat++; next_beat(); end
            end

            if (awvalid && awready) begin
                aw_pend = 0; w_act = 1;
                if (aw_exp_q.size() == 0) timeout_fail("aw_unexpected");
                else begin aw_e = aw_exp_q.pop_front(); check("aw_fields", {awid, awaddr, awlen, awsize}, {4'd1, aw_e}); end
            end
            if (wvalid && wready) begin
                w_beats++;
                if (w_exp_q.size() == 0) timeout_fail("w_unexpected");
                else begin w_e = w_exp_q.pop_front(); check("w_beat", {wdata, wstrb, wlast}, w_e); end
                if (wlast) begin w_act = 0; b_pend = 1; end
            end
            if (bvalid && bready && b_pend) begin
                b_pend = 0; wr_busy = 0; b_cnt++; b_cyc = cyc;
            end

            if (i_arvalid && i_arready) begin
                ar_exp_q.push_back({1'b0, i_araddr, i_arlen, i_arsize});
                ar_pend = 1; last_owner = 0; gnt_q.push_back(1'b0);
            end
            if (d_arvalid && d_arready) begin
                ar_exp_q.push_back({1'b1, d_araddr, d_arlen, d_arsize});
                ar_pend = 1; last_owner = 1; gnt_q.push_back(1'b1); d_gnt_cyc = cyc;
            end
            if (d_awvalid && d_awready) begin
                aw_exp_q.push_back({d_awaddr, d_awlen, d_awsize});
                aw_pend = 1; wr_busy = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ev(input int which, input string name);
        bit hit = 0;
        for (int t = 0; t < 4000 && !hit; t++) begin
            @(negedge clk);
            case (which)
                0:       hit = i_arready;
                1:       hit = d_arready;
                2:       hit = d_awready;
                3:       hit = d_wready;
                default: hit = d_bvalid && d_bready;
            endcase
        end
        if (!hit) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name, input bit rd_only);
        bit done = 0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(posedge clk);
            done = !ar_pend && !r_act && (rd_only || (!aw_pend && !w_act && !b_pend && !wr_busy));
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic i_read(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
        @(posedge clk); #1;
        i_araddr = a; i_arlen = l; i_arsize = s; i_arvalid = 1;
        wait_ev(0, "i_ar_grant");
        @(posedge clk); #1;
        i_arvalid = 0;
    endtask

    task automatic d_read(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
        @(posedge clk); #1;
        d_araddr = a; d_arlen = l; d_arsize = s; d_arvalid = 1;
        wait_ev(1, "d_ar_grant");
        @(posedge clk); #1;
        d_arvalid = 0;
    endtask

    task automatic d_write(input logic [31:0] a, input logic [3:0] l, input logic [3:0] strb, input bit rnd_strb);
        logic [31:0] wd[16];
        logic [3:0]  ws[16];
        for (int k = 0; k <= int'(l); k++) begin
            wd[k] = $urandom;
            ws[k] = rnd_strb ? 4'($urandom_range(0, 15)) : strb;
            w_exp_q.push_back({wd[k], ws[k], k == int'(l)});
        end
        @(posedge clk); #1;
        d_awaddr = a; d_awlen = l; d_awsize = 3'd2; d_awvalid = 1;
        wait_ev(2, "d_aw_grant");
        @(posedge clk); #1;
        d_awvalid = 0;
        for (int k = 0; k <= int'(l); k++) begin
            d_wdata = wd[k]; d_wstrb = ws[k]; d_wlast = (k == int'(l)); d_wvalid = 1;
            wait_ev(3, "d_wready");
            @(posedge clk); #1;
        end
        d_wvalid = 0; d_wlast = 0;
        wait_ev(4, "d_b_handshake");
    endtask

    // ---------------- main sequence ----------------
    int          i0, d0, w0, b0;
    logic [3:0]  order;
    bit          seen;

    task automatic check_order(input string name, input int n, input logic [3:0] exp);
        order = '0;
        for (int k = 0; k < gnt_q.size() && k < 4; k++) order[3-k] = gnt_q[k];
        check(name, {28'(gnt_q.size()), order}, {28'(n), exp});
    endtask

    initial begin
        rst = 1;
        i_araddr = 0; i_arlen = 0; i_arsize = 0; i_arvalid = 0;
        d_araddr = 0; d_arlen = 0; d_arsize = 0; d_arvalid = 0;
        d_awaddr = 0; d_awlen = 0; d_awsize = 0; d_awvalid = 0;
        d_wdata = 0; d_wstrb = 0; d_wlast = 0; d_wvalid = 0;
        data_is_index = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_valids", {i_arready, d_arready, i_rvalid, d_rvalid, d_awready, d_wready, d_bvalid,
                               arvalid, rready, awvalid, wvalid, bready}, 0);
        check("reset_states", {dbg_rd_state_o, dbg_wr_state_o}, 0);
        check("reset_latched", {arid, araddr, arlen, arsize, awaddr, awlen, awsize}, 0);

        // lone icache burst, data = beat index
        data_is_index = 1;
        i0 = i_beats; d0 = d_beats;
        i_read(32'h1FC0_0000, 4'd7, 3'd2);
        wait_idle("lone_idle", 1'b1);
        data_is_index = 0;
        check("lone_i_beats", 32'(i_beats - i0), 8);
        check("lone_d_beats", 32'(d_beats - d0), 0);
        @(negedge clk);
        check("lone_rd_state", dbg_rd_state_o, 0);

        // same-cycle ties, one request each per round
        for (int r = 0; r < 3; r++) begin
            gnt_q.delete();
            fork
                i_read(32'h0000_1000 + 32'(r * 64), 4'd3, 3'd2);
                d_read(32'h0000_2000 + 32'(r * 64), 4'd3, 3'd2);
            join
            wait_idle("tie_round_idle", 1'b1);
            check_order("tie_round_order", 2, 4'b1000);
        end

        // back-to-back: both caches keep requesting
        gnt_q.delete();
        fork
            begin i_read(32'h0000_3000, 4'd3, 3'd2); i_read(32'h0000_3040, 4'd3, 3'd2); end
            begin d_read(32'h0000_4000, 4'd3, 3'd2); d_read(32'h0000_4040, 4'd3, 3'd2); end
        join
        wait_idle("b2b_idle", 1'b1);
`ifdef ARB_RR_EN
        check_order("b2b_order", 4, 4'b1010);
`else
        check_order("b2b_order", 4, 4'b1100);
`endif

        // dcache write burst
        w0 = w_beats; b0 = b_cnt;
        d_write(32'h8000_0040, 4'd3, 4'hF, 1'b0);
        wait_idle("write_idle", 1'b0);
        check("write_w_beats", 32'(w_beats - w0), 4);
        check("write_b_count", 32'(b_cnt - b0), 1);

        // dcache read raised during W_DATA is held until the B handshake
        fork
            d_write(32'h8000_0100, 4'd7, 4'h0, 1'b1);
            begin
                seen = 0;
                for (int t = 0; t < 4000 && !seen; t++) begin @(posedge clk); seen = w_act; end
                if (!seen) timeout_fail("w_data_phase");
                d_read(32'h0000_5000, 4'd1, 3'd2);
            end
        join
        wait_idle("raw_idle", 1'b0);
        check("raw_grant_after_b", 32'(d_gnt_cyc - b_cyc), 1);

        // reset in the middle of a read burst
        i_read(32'h0000_6000, 4'd7, 3'd2);
        seen = 0;
        for (int t = 0; t < 4000 && !seen; t++) begin @(posedge clk); seen = r_act && (burst_beats == 2); end
        if (!seen) timeout_fail("mid_burst");
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("rst_mid_valids", {i_arready, d_arready, i_rvalid, d_rvalid, d_awready, d_wready, d_bvalid,
                                 arvalid, rready, awvalid, wvalid, bready}, 0);
        check("rst_mid_states", {dbg_rd_state_o, dbg_wr_state_o}, 0);
        i0 = i_beats;
        i_read(32'h0000_7000, 4'd2, 3'd2);
        wait_idle("post_rst_idle", 1'b1);
        check("post_rst_beats", 32'(i_beats - i0), 3);

        // randomized concurrent traffic
        fork
            for (int n = 0; n < 15; n++)
                i_read($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)));
            for (int n = 0; n < 15; n++) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_read($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)));
                    wait_idle("rand_d_rd", 1'b1);
                end else begin
                    d_write($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), 4'h0, 1'b1);
                end
            end
        join
        wait_idle("rand_idle", 1'b0);
        repeat (2) @(posedge clk);
        check("drain_queues", {ar_exp_q.size(), aw_exp_q.size(), w_exp_q.size(),
                               ir_exp_q.size() + dr_exp_q.size()}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
